rank_filter: RTL and testbench
==============================

RANK_FILTER -- requirements
Module: rank_filter

Interface
REQ-001 Parameter WIN, default 3, meaning window edge in pixels; legal values 3 and 5; N = WIN*WIN.
REQ-002 Parameter REG_EVERY, default N, meaning sort-network stages per pipeline register; SHALL divide N exactly, else elaboration error.
REQ-003 Parameter CNT_W, default 32, meaning width of the output beat counter.
REQ-004 clk  input  1  the single clock.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 axis_i  axis_if.slave  WIN x WIN pixel_pkg::pixel_t  window in; data[i][j], row i, column j.
REQ-007 axis_o  axis_if.master  WIN x WIN pixel_pkg::pixel_t  filtered result out.
REQ-008 rank_sel  input  $clog2(N)  sorted index to output; 0 = min, N/2 = median, N-1 = max.
REQ-009 bypass  input  1  1 = output the unfiltered centre pixel.
REQ-010 out_cnt  output  CNT_W  count of transferred output beats.

Function
REQ-011 Pixel ordering SHALL be the ordering implemented by pixel_sort; the sort network SHALL be N odd-even transposition stages built from pixel_sort.
REQ-012 Input beat accepted when axis_i.vld && axis_i.rdy; the accepted window, rank_sel and bypass SHALL be captured together into the input register.
REQ-013 rank_sel and bypass SHALL travel down the pipeline with their beat; a change takes effect on the next accepted beat only.
REQ-014 A pipeline register SHALL follow every REG_EVERY stages; the last one is the output register.
REQ-015 Latency from acceptance to axis_o.vld SHALL be 1 + N/REG_EVERY cycles with no stall (WIN=3, REG_EVERY=9: 2 cycles).
REQ-016 Global enable en = !axis_o.vld || axis_o.rdy; all pipeline data and valid registers SHALL advance only when en=1.
REQ-017 axis_i.rdy SHALL equal en (combinational from axis_o.rdy permitted).
REQ-018 While axis_o.vld=1 and axis_o.rdy=0, axis_o.data SHALL hold stable; no beat lost or duplicated.
REQ-019 Empty pipeline slots (valid=0) SHALL advance when en=1, collapsing bubbles ahead of a stall.
REQ-020 Output: axis_o.data[WIN/2][WIN/2] = sorted[rank_sel] (bypass=0) or the input centre pixel (bypass=1); all other positions SHALL be zero.
REQ-021 rank_sel >= N SHALL be treated as N-1.
REQ-022 out_cnt SHALL increment by 1 on each cycle with axis_o.vld && axis_o.rdy, and wrap from 2^CNT_W-1 to 0.
REQ-023 Simultaneous input accept and output transfer SHALL sustain one beat per cycle.

Reset
REQ-024 With rst=1 at a clock edge, all valid bits, axis_o.vld and out_cnt SHALL be 0 after that edge.
REQ-025 axis_o.data SHALL be zero after reset; internal data registers need no reset.
REQ-026 Reset mid-operation SHALL discard all in-flight beats; no beat accepted before reset may appear after it.
REQ-027 During rst=1, axis_i.rdy SHALL be 1 (pipeline empty); inputs accepted in the reset cycle SHALL be dropped.

Verification
REQ-028 Test pixels SHALL have all channels equal to value v, so ordering is unambiguous.
REQ-029 WIN=3, window v=8,7,...,0, rank_sel=4, rdy=1 -> centre out = 4 two cycles later, other positions 0, out_cnt=1.
REQ-030 Same window, rank_sel=0 then 8 on consecutive beats -> outputs 0 then 8 on consecutive cycles.
REQ-031 bypass=1, window with centre v=9 and all others 1 -> output centre 9.
REQ-032 Stream 10 beats, axis_o.rdy low for 3 cycles mid-stream -> all 10 results in order, data stable while stalled, out_cnt=10.
REQ-033 WIN=5, REG_EVERY=5, values 24..0 shuffled, rank_sel=12 -> output 12 at latency 6; rank_sel=31 -> output 24.
REQ-034 rst pulsed with 2 beats in flight -> no axis_o.vld afterwards until a new beat; out_cnt=0.

Source files
------------

// File: rtl/rank_filter.sv
// Pipelined WIN x WIN rank-order filter: odd-even transposition sort of the window,
// then one sorted rank (or the untouched centre pixel) placed at the window centre.

module pixel_sort #(
    parameter int PIX_W = 24
) (
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    output logic [PIX_W-1:0] lo,
    output logic [PIX_W-1:0] hi
);

    // Pixels order as plain unsigned words (channel order R,G,B from MSB).
    always_comb begin
        if (a > b) begin
            lo = b;
            hi = a;
        end else begin
            lo = a;
            hi = b;
        end
    end

endmodule

module rank_filter #(
    parameter int WIN       = 3,
    parameter int REG_EVERY = WIN * WIN,
    parameter int CNT_W     = 32,
    parameter int CH_W      = 8,
    parameter int NCH       = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              axis_i_vld,
    output logic                              axis_i_rdy,
    input  logic [WIN*WIN*CH_W*NCH-1:0]       axis_i_data,
    output logic                              axis_o_vld,
    input  logic                              axis_o_rdy,
    output logic [WIN*WIN*CH_W*NCH-1:0]       axis_o_data,
    input  logic [$clog2(WIN*WIN)-1:0]        rank_sel,
    input  logic                              bypass,
    output logic [CNT_W-1:0]                  out_cnt
);

    localparam int N     = WIN * WIN;
    localparam int PIX_W = CH_W * NCH;
    localparam int NP    = N * PIX_W;
    localparam int RW    = $clog2(N);
    localparam int G     = N / REG_EVERY;
    localparam int CTR   = (WIN / 2) * WIN + (WIN / 2);
    localparam logic [RW-1:0] RANK_MAX = RW'(N - 1);

    genvar gi, gj;

    if (WIN != 3 && WIN != 5) begin : g_bad_win
        $error("rank_filter: WIN must be 3 or 5");
    end
    if (N % REG_EVERY != 0) begin : g_bad_reg_every
        $error("rank_filter: REG_EVERY must divide WIN*WIN");
    end

    // Slot 0 is the input register; slot g feeds sort group g.
    logic [NP-1:0]    pipe_data_q [G];
    logic [NP-1:0]    pipe_data_d [G];
    logic [PIX_W-1:0] pipe_ctr_q  [G];
    logic [PIX_W-1:0] pipe_ctr_d  [G];
    logic [RW-1:0]    pipe_rank_q [G];
    logic [RW-1:0]    pipe_rank_d [G];
    logic             pipe_byp_q  [G];
    logic             pipe_byp_d  [G];
    logic             pipe_vld_q  [G];
    logic             pipe_vld_d  [G];

    logic             out_vld_q, out_vld_d;
    logic [PIX_W-1:0] out_pix_q, out_pix_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NP-1:0]    grp_out [G];
    logic             en;
    logic             xfer;
    logic [RW-1:0]    rank_c;
    logic [PIX_W-1:0] sel_pix;

    // Odd-even transposition network: stage gi compares pairs starting at index gi%2.
    for (gi = 0; gi < N; gi++) begin : g_stage
        logic [NP-1:0] s_in;
        logic [NP-1:0] s_out;

        if (gi % REG_EVERY == 0) begin : g_head
            assign s_in = pipe_data_q[gi / REG_EVERY];
        end else begin : g_chain
            assign s_in = g_stage[gi-1].s_out;
        end

        for (gj = 0; gj < N; gj++) begin : g_elem
            if (gj >= gi % 2 && (gj - gi % 2) % 2 == 0 && gj + 1 < N) begin : g_cmp
                pixel_sort #(.PIX_W(PIX_W)) u_sort (
                    .a  (s_in [gj*PIX_W +: PIX_W]),
                    .b  (s_in [(gj+1)*PIX_W +: PIX_W]),
                    .lo (s_out[gj*PIX_W +: PIX_W]),
                    .hi (s_out[(gj+1)*PIX_W +: PIX_W])
                );
            end else if (!(gj >= gi % 2 + 1 && (gj - 1 - gi % 2) % 2 == 0)) begin : g_pass
                assign s_out[gj*PIX_W +: PIX_W] = s_in[gj*PIX_W +: PIX_W];
            end
        end
    end

    for (gi = 0; gi < G; gi++) begin : g_grp
        assign grp_out[gi] = g_stage[gi*REG_EVERY + REG_EVERY - 1].s_out;
    end

    assign en         = !out_vld_q || axis_o_rdy;
    assign xfer       = out_vld_q && axis_o_rdy;
    assign axis_i_rdy = en || rst;
    assign axis_o_vld = out_vld_q;
    assign out_cnt    = cnt_q;

    always_comb begin
        rank_c  = (pipe_rank_q[G-1] > RANK_MAX) ? RANK_MAX : pipe_rank_q[G-1];
        sel_pix = '0;
        for (int k = 0; k < N; k++) begin
            if (rank_c == RW'(k)) begin
                sel_pix = grp_out[G-1][k*PIX_W +: PIX_W];
            end
        end
    end

    always_comb begin
        for (int g = 0; g < G; g++) begin
            pipe_data_d[g] = pipe_data_q[g];
            pipe_ctr_d[g]  = pipe_ctr_q[g];
            pipe_rank_d[g] = pipe_rank_q[g];
            pipe_byp_d[g]  = pipe_byp_q[g];
            pipe_vld_d[g]  = pipe_vld_q[g];
        end
        out_vld_d = out_vld_q;
        out_pix_d = out_pix_q;
        cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, xfer};

        // Whole pipeline moves in lockstep, bubbles included, so a stall never splits beats.
        if (en) begin
            pipe_data_d[0] = axis_i_data;
            pipe_ctr_d[0]  = axis_i_data[CTR*PIX_W +: PIX_W];
            pipe_rank_d[0] = rank_sel;
            pipe_byp_d[0]  = bypass;
            pipe_vld_d[0]  = axis_i_vld;
            for (int g = 1; g < G; g++) begin
                pipe_data_d[g] = grp_out[g-1];
                pipe_ctr_d[g]  = pipe_ctr_q[g-1];
                pipe_rank_d[g] = pipe_rank_q[g-1];
                pipe_byp_d[g]  = pipe_byp_q[g-1];
                pipe_vld_d[g]  = pipe_vld_q[g-1];
            end
            out_vld_d = pipe_vld_q[G-1];
            if (pipe_vld_q[G-1]) begin
                out_pix_d = pipe_byp_q[G-1] ? pipe_ctr_q[G-1] : sel_pix;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int g = 0; g < G; g++) begin
            pipe_data_q[g] <= pipe_data_d[g];
            pipe_ctr_q[g]  <= pipe_ctr_d[g];
            pipe_rank_q[g] <= pipe_rank_d[g];
            pipe_byp_q[g]  <= pipe_byp_d[g];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int g = 0; g < G; g++) begin
                pipe_vld_q[g] <= 1'b0;
            end
            out_vld_q <= 1'b0;
            out_pix_q <= '0;
            cnt_q     <= '0;
        end else begin
            for (int g = 0; g < G; g++) begin
                pipe_vld_q[g] <= pipe_vld_d[g];
            end
            out_vld_q <= out_vld_d;
            out_pix_q <= out_pix_d;
            cnt_q     <= cnt_d;
        end
    end

    // Only the centre position carries a result; the rest of the window is zero.
    always_comb begin
        axis_o_data = '0;
        axis_o_data[CTR*PIX_W +: PIX_W] = out_pix_q;
    end

endmodule

// File: tb/tb_rank_filter.sv
// Directed bench for rank_filter: a WIN=3 instance driven from a vector table plus
// hand-written stall/reset sequences, and a WIN=5 REG_EVERY=5 instance for latency.

module tb_rank_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         i_vld3, i_rdy3, o_vld3, o_rdy3, byp3;
    logic [215:0] i_data3, o_data3;
    logic [3:0]   rank3;
    logic [31:0]  cnt3;

    logic         i_vld5, i_rdy5, o_vld5, o_rdy5, byp5;
    logic [599:0] i_data5, o_data5;
    logic [4:0]   rank5;
    logic [31:0]  cnt5;

    rank_filter #(.WIN(3)) dut3 (
        .clk(clk), .rst(rst),
        .axis_i_vld(i_vld3), .axis_i_rdy(i_rdy3), .axis_i_data(i_data3),
        .axis_o_vld(o_vld3), .axis_o_rdy(o_rdy3), .axis_o_data(o_data3),
        .rank_sel(rank3), .bypass(byp3), .out_cnt(cnt3)
    );

    rank_filter #(.WIN(5), .REG_EVERY(5)) dut5 (
        .clk(clk), .rst(rst),
        .axis_i_vld(i_vld5), .axis_i_rdy(i_rdy5), .axis_i_data(i_data5),
        .axis_o_vld(o_vld5), .axis_o_rdy(o_rdy5), .axis_o_data(o_data5),
        .rank_sel(rank5), .bypass(byp5), .out_cnt(cnt5)
    );

    typedef struct packed {
        int   w;
        int   rank;
        logic byp;
        int   exp;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   win_tbl [3][9];
    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [23:0] pix(input int v);
        logic [7:0] b;
        b = 8'(v);
        return {b, b, b};
    endfunction

    function automatic logic [215:0] mk3(input int w);
        logic [215:0] d;
        for (int p = 0; p < 9; p++) d[p*24 +: 24] = pix(win_tbl[w][p]);
        return d;
    endfunction

    function automatic logic [599:0] mk5();
        logic [599:0] d;
        for (int p = 0; p < 25; p++) d[p*24 +: 24] = pix((p * 7) % 25);
        return d;
    endfunction

    function automatic logic [23:0] ctr3();
        return o_data3[4*24 +: 24];
    endfunction

    function automatic logic others3_nz();
        logic [215:0] m;
        m = o_data3;
        m[4*24 +: 24] = '0;
        return (m != '0);
    endfunction

    function automatic logic others5_nz();
        logic [599:0] m;
        m = o_data5;
        m[12*24 +: 24] = '0;
        return (m != '0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat into the WIN=3 instance; checks exact 2-cycle latency and the result.
    task automatic apply3(input vec_t v);
        i_vld3  = 1'b1;
        i_data3 = mk3(v.w);
        rank3   = 4'(v.rank);
        byp3    = v.byp;
        tick();
        i_vld3  = 1'b0;
        i_data3 = '1;
        rank3   = 4'd0;
        byp3    = ~v.byp;
        chk("lat3_early_vld", 64'(o_vld3), 64'(0));
        tick();
        chk("lat3_vld", 64'(o_vld3), 64'(1));
        chk("vec_centre", 64'(ctr3()), 64'(pix(v.exp)));
        chk("vec_others_zero", 64'(others3_nz()), 64'(0));
    endtask

    // One beat into the WIN=5 instance; checks exact 6-cycle latency and the result.
    task automatic apply5(input int rank, input logic byp, input int exp);
        i_vld5  = 1'b1;
        i_data5 = mk5();
        rank5   = 5'(rank);
        byp5    = byp;
        tick();
        i_vld5  = 1'b0;
        rank5   = 5'd0;
        byp5    = ~byp;
        for (int c = 1; c < 6; c++) begin
            chk("lat5_early_vld", 64'(o_vld5), 64'(0));
            tick();
        end
        chk("lat5_vld", 64'(o_vld5), 64'(1));
        chk("w5_centre", 64'(o_data5[12*24 +: 24]), 64'(pix(exp)));
        chk("w5_others_zero", 64'(others5_nz()), 64'(0));
        tick();
    endtask

    initial begin
        int            sent, rcvd;
        int            exp_q[$];
        logic [23:0]   hold;
        logic          stalled_prev;

        win_tbl[0] = '{8, 7, 6, 5, 4, 3, 2, 1, 0};
        win_tbl[1] = '{1, 1, 1, 1, 9, 1, 1, 1, 1};
        win_tbl[2] = '{3, 1, 4, 1, 5, 9, 2, 6, 5};
        vecs[0]  = '{0, 4,  1'b0, 4};
        vecs[1]  = '{0, 0,  1'b0, 0};
        vecs[2]  = '{0, 8,  1'b0, 8};
        vecs[3]  = '{0, 15, 1'b0, 8};
        vecs[4]  = '{1, 0,  1'b1, 9};
        vecs[5]  = '{1, 8,  1'b0, 9};
        vecs[6]  = '{1, 0,  1'b0, 1};
        vecs[7]  = '{2, 4,  1'b0, 4};
        vecs[8]  = '{2, 7,  1'b0, 6};
        vecs[9]  = '{2, 2,  1'b1, 5};
        vecs[10] = '{2, 8,  1'b0, 9};

        rst = 1'b1;
        i_vld3 = 1'b0; i_data3 = '0; rank3 = '0; byp3 = 1'b0; o_rdy3 = 1'b1;
        i_vld5 = 1'b0; i_data5 = '0; rank5 = '0; byp5 = 1'b0; o_rdy5 = 1'b1;
        tick();
        tick();
        chk("rst_in_rdy", 64'(i_rdy3), 64'(1));
        rst = 1'b0;
        chk("rst_out_vld", 64'(o_vld3), 64'(0));
        chk("rst_out_data", 64'(o_data3 != '0), 64'(0));
        chk("rst_cnt", 64'(cnt3), 64'(0));
        chk("rst_out_vld5", 64'(o_vld5), 64'(0));

        apply3(vecs[0]);
        tick();
        chk("cnt_after_first", 64'(cnt3), 64'(1));
        for (int i = 1; i < 11; i++) begin
            apply3(vecs[i]);
            tick();
        end

        // Back-to-back beats with differing rank_sel.
        i_vld3 = 1'b1; i_data3 = mk3(0); rank3 = 4'd0; byp3 = 1'b0;
        tick();
        rank3 = 4'd8;
        tick();
        i_vld3 = 1'b0; rank3 = 4'd4;
        chk("b2b_vld0", 64'(o_vld3), 64'(1));
        chk("b2b_first", 64'(ctr3()), 64'(pix(0)));
        tick();
        chk("b2b_vld1", 64'(o_vld3), 64'(1));
        chk("b2b_second", 64'(ctr3()), 64'(pix(8)));
        tick();
        chk("b2b_drain", 64'(o_vld3), 64'(0));

        // Streaming with a 3-cycle output stall.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("stream_cnt_start", 64'(cnt3), 64'(0));
        sent = 0;
        rcvd = 0;
        stalled_prev = 1'b0;
        hold = '0;
        for (int cyc = 0; cyc < 60 && rcvd < 10; cyc++) begin
            o_rdy3 = !(cyc >= 5 && cyc < 8);
            i_vld3 = (sent < 10);
            i_data3 = mk3(0);
            rank3 = 4'((sent * 4) % 9);
            byp3 = 1'b0;
            #1;
            if (stalled_prev) chk("stall_hold", 64'(ctr3()), 64'(hold));
            if (stalled_prev) chk("stall_in_rdy_was_low_vld", 64'(o_vld3), 64'(1));
            if (o_vld3 && o_rdy3) begin
                if (exp_q.size() == 0) begin
                    chk("stream_extra_beat", 64'(1), 64'(0));
                end else begin
                    chk("stream_data", 64'(ctr3()), 64'(pix(exp_q.pop_front())));
                end
                rcvd++;
            end
            stalled_prev = o_vld3 && !o_rdy3;
            hold = ctr3();
            if (i_vld3 && i_rdy3) begin
                exp_q.push_back((sent * 4) % 9);
                sent++;
            end
            @(posedge clk);
            #1;
        end
        i_vld3 = 1'b0;
        o_rdy3 = 1'b1;
        chk("stream_rcvd", 64'(rcvd), 64'(10));
        chk("stream_cnt", 64'(cnt3), 64'(10));

        // Reset with beats in flight, plus a beat offered during reset.
        i_vld3 = 1'b1; i_data3 = mk3(0); rank3 = 4'd4; byp3 = 1'b0;
        tick();
        tick();
        o_rdy3 = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_in_rdy", 64'(i_rdy3), 64'(1));
        tick();
        rst = 1'b0;
        i_vld3 = 1'b0;
        o_rdy3 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk("rst_flush_vld", 64'(o_vld3), 64'(0));
            tick();
        end
        chk("rst_flush_cnt", 64'(cnt3), 64'(0));
        apply3(vecs[2]);
        tick();
        chk("rst_after_cnt", 64'(cnt3), 64'(1));

        apply5(12, 1'b0, 12);
        apply5(31, 1'b0, 24);
        apply5(0, 1'b1, 9);
        chk("w5_cnt", 64'(cnt5), 64'(3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
